// File: rtl/cursor_stroke_if.sv
// cursor_stroke_if: mouse packet input and stroke pixel output bundle
//   in_valid/in_ready, delta_x/delta_y, btn_left/btn_right : mouse packet handshake
//   pos_x/pos_y                                            : current cursor position
//   pix_valid/pix_ready, pix_x/pix_y, pix_erase            : stroke pixel handshake
//   busy                                                   : stroke in progress
interface cursor_stroke_if #(
   parameter int POS_W   = 7,
   parameter int DELTA_W = 8
);
   logic               in_valid, in_ready, btn_left, btn_right;
   logic [DELTA_W-1:0] delta_x, delta_y;
   logic [POS_W-1:0]   pos_x, pos_y, pix_x, pix_y;
   logic               pix_valid, pix_ready, pix_erase, busy;
   modport master (
      output in_valid, delta_x, delta_y, btn_left, btn_right, pix_ready,
      input  in_ready, pos_x, pos_y, pix_valid, pix_x, pix_y, pix_erase, busy
   );
   modport slave (
      input  in_valid, delta_x, delta_y, btn_left, btn_right, pix_ready,
      output in_ready, pos_x, pos_y, pix_valid, pix_x, pix_y, pix_erase, busy
   );
endinterface

// File: rtl/cursor_stroke.sv
// cursor_stroke: bounded cursor tracker with Bresenham stroke generation
//   clk, rst : clock, synchronous active-high reset
//   bus      : cursor_stroke_if.slave (mouse packets in, cursor position and stroke pixels out)
module cursor_stroke #(
   parameter int X_MAX   = 63,
   parameter int Y_MAX   = 63,
   parameter int POS_W   = 7,
   parameter int DELTA_W = 8,
   parameter int SHIFT   = 0,
   parameter int WRAP    = 0,
   parameter int INV_Y   = 0,
   parameter int X_RST   = 32,
   parameter int Y_RST   = 32
) (
   input logic           clk,
   input logic           rst,
   cursor_stroke_if.slave bus
);
   localparam int W = POS_W + 2;
   localparam int E = POS_W + 3;
   localparam logic signed [W-1:0] XM = W'(X_MAX);
   localparam logic signed [W-1:0] YM = W'(Y_MAX);
   typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;
   state_t state_q, state_d;
   logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d, tx_q, tx_d, ty_q, ty_d, cx_q, cx_d, cy_q, cy_d;
   logic pen_q, pen_d, erase_q, erase_d, pen_prev_q, pen_prev_d, wrap_q, wrap_d, xn_q, xn_d, yn_q, yn_d;
   logic signed [E-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   // returns {wrapped, bounded coordinate}
   function automatic logic [POS_W:0] fit(input logic signed [W-1:0] r, input logic signed [W-1:0] m);
      logic [POS_W-1:0] v;
      logic w;
      w = WRAP != 0 && (r[W-1] || r > m);
      v = POS_W'(!r[W-1] && r <= m ? r : WRAP != 0 ? (r[W-1] ? r + m + W'(1) : r - m - W'(1)) : r[W-1] ? '0 : m);
      return {w, v};
   endfunction
   logic signed [W-1:0] sdx, shy, sdy, rx, ry;
   logic [POS_W:0] fx, fy;
   assign sdx = $signed({{(W-DELTA_W){bus.delta_x[DELTA_W-1]}}, bus.delta_x}) >>> SHIFT;
   assign shy = $signed({{(W-DELTA_W){bus.delta_y[DELTA_W-1]}}, bus.delta_y}) >>> SHIFT;
   assign sdy = INV_Y != 0 ? -shy : shy;
   assign rx = $signed({2'b00, pos_x_q}) + sdx;
   assign ry = $signed({2'b00, pos_y_q}) + sdy;
   assign fx = fit(rx, XM);
   assign fy = fit(ry, YM);
   // one Bresenham stepper shared by SETUP (skipping the start point) and EMIT
   logic setup, snx, sny, hx, hy, dxn, dyn, at_tgt, at_start;
   logic signed [E-1:0] adx, ady, be, bdx, bdy, e2, nerr;
   logic [POS_W-1:0] bx, by, stx, sty;
   assign setup = state_q == SETUP;
   assign snx = tx_q < pos_x_q;
   assign sny = ty_q < pos_y_q;
   assign adx = E'(snx ? pos_x_q - tx_q : tx_q - pos_x_q);
   assign ady = E'(sny ? pos_y_q - ty_q : ty_q - pos_y_q);
   assign be = setup ? adx - ady : err_q;
   assign bdx = setup ? adx : dx_q;
   assign bdy = setup ? ady : dy_q;
   assign bx = setup ? pos_x_q : cx_q;
   assign by = setup ? pos_y_q : cy_q;
   assign dxn = setup ? snx : xn_q;
   assign dyn = setup ? sny : yn_q;
   assign e2 = be <<< 1;
   assign hx = e2 > -bdy;
   assign hy = e2 < bdx;
   assign stx = hx ? (dxn ? bx - 1 : bx + 1) : bx;
   assign sty = hy ? (dyn ? by - 1 : by + 1) : by;
   assign nerr = be - (hx ? bdy : '0) + (hy ? bdx : '0);
   assign at_tgt = cx_q == tx_q && cy_q == ty_q;
   assign at_start = pos_x_q == tx_q && pos_y_q == ty_q;
   always_comb begin
      state_d = state_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      tx_d = tx_q;
      ty_d = ty_q;
      cx_d = cx_q;
      cy_d = cy_q;
      pen_d = pen_q;
      erase_d = erase_q;
      pen_prev_d = pen_prev_q;
      wrap_d = wrap_q;
      xn_d = xn_q;
      yn_d = yn_q;
      dx_d = dx_q;
      dy_d = dy_q;
      err_d = err_q;
      if (state_q == IDLE && bus.in_valid) begin
         state_d = SETUP;
         tx_d = fx[POS_W-1:0];
         ty_d = fy[POS_W-1:0];
         wrap_d = fx[POS_W] | fy[POS_W];
         pen_d = bus.btn_left | bus.btn_right;
         erase_d = bus.btn_right;
      end else if (setup) begin
         pos_x_d = tx_q;
         pos_y_d = ty_q;
         pen_prev_d = pen_q;
         xn_d = snx;
         yn_d = sny;
         // a wrapped move collapses to the single target pixel
         dx_d = wrap_q ? '0 : adx;
         dy_d = wrap_q ? '0 : ady;
         err_d = wrap_q ? '0 : pen_prev_q ? nerr : be;
         cx_d = wrap_q ? tx_q : pen_prev_q ? stx : pos_x_q;
         cy_d = wrap_q ? ty_q : pen_prev_q ? sty : pos_y_q;
         state_d = pen_q && (wrap_q || !pen_prev_q || !at_start) ? EMIT : IDLE;
      end else if (state_q == EMIT && bus.pix_ready) begin
         state_d = at_tgt ? IDLE : EMIT;
         cx_d = at_tgt ? cx_q : stx;
         cy_d = at_tgt ? cy_q : sty;
         err_d = at_tgt ? err_q : nerr;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pos_x_q <= POS_W'(X_RST);
         pos_y_q <= POS_W'(Y_RST);
         tx_q <= '0;
         ty_q <= '0;
         cx_q <= '0;
         cy_q <= '0;
         pen_q <= 1'b0;
         erase_q <= 1'b0;
         pen_prev_q <= 1'b0;
         wrap_q <= 1'b0;
         xn_q <= 1'b0;
         yn_q <= 1'b0;
         dx_q <= '0;
         dy_q <= '0;
         err_q <= '0;
      end else begin
         state_q <= state_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         tx_q <= tx_d;
         ty_q <= ty_d;
         cx_q <= cx_d;
         cy_q <= cy_d;
         pen_q <= pen_d;
         erase_q <= erase_d;
         pen_prev_q <= pen_prev_d;
         wrap_q <= wrap_d;
         xn_q <= xn_d;
         yn_q <= yn_d;
         dx_q <= dx_d;
         dy_q <= dy_d;
         err_q <= err_d;
      end
   end
   assign bus.in_ready = state_q == IDLE;
   assign bus.busy = state_q != IDLE;
   assign bus.pix_valid = state_q == EMIT;
   assign bus.pix_x = cx_q;
   assign bus.pix_y = cy_q;
   assign bus.pix_erase = erase_q;
   assign bus.pos_x = pos_x_q;
   assign bus.pos_y = pos_y_q;
endmodule

// File: tb/tb_cursor_stroke.sv
// tb_cursor_stroke: scoreboard bench for a clamping and a wrapping cursor_stroke
module tb_cursor_stroke;
   localparam int PW = 7;
   logic clk = 0, rst = 1, iv = 0, bl = 0, br = 0, mpp = 0;
   logic [7:0] ddx = 0, ddy = 0;
   logic [1:0] pr = 2'b11;
   int rmode = 0, cmp = 0, bad = 0, mxa, mya, mxb, myb, na, nb, h0, h1;
   logic [2*PW:0] q[2][$];
   logic [2*PW:0] tmp[$];
   logic [2*PW:0] h[2];
   logic s[2];
   int hs[2];
   always #5 clk = ~clk;
   cursor_stroke_if #(.POS_W(PW), .DELTA_W(8)) ia ();
   cursor_stroke_if #(.POS_W(PW), .DELTA_W(8)) ib ();
   assign ia.in_valid = iv;
   assign ia.delta_x = ddx;
   assign ia.delta_y = ddy;
   assign ia.btn_left = bl;
   assign ia.btn_right = br;
   assign ia.pix_ready = pr[0];
   assign ib.in_valid = iv;
   assign ib.delta_x = ddx;
   assign ib.delta_y = ddy;
   assign ib.btn_left = bl;
   assign ib.btn_right = br;
   assign ib.pix_ready = pr[1];
   cursor_stroke ua (.clk(clk), .rst(rst), .bus(ia));
   cursor_stroke #(.WRAP(1), .SHIFT(2), .INV_Y(1)) ub (.clk(clk), .rst(rst), .bus(ib));
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", n, act, exp);
      end
   endtask
   task automatic axis(input int p, input int d, input int w, output int t, output logic wr);
      t = p + d;
      wr = 0;
      if (w != 0 && (t < 0 || t > 63)) begin
         wr = 1;
         t = t < 0 ? t + 64 : t - 64;
      end else t = t < 0 ? 0 : t > 63 ? 63 : t;
   endtask
   task automatic line(input int sx, input int sy, input int tx, input int ty, input logic skip, input logic er);
      int x = sx, y = sy, e2;
      int ax = tx > sx ? tx - sx : sx - tx;
      int ay = ty > sy ? ty - sy : sy - ty;
      int err = ax - ay;
      logic first = 1;
      tmp.delete();
      forever begin
         if (!(first && skip)) tmp.push_back({er, PW'(x), PW'(y)});
         if (x == tx && y == ty) break;
         e2 = 2 * err;
         if (e2 > -ay) begin err -= ay; x += tx >= sx ? 1 : -1; end
         if (e2 < ax) begin err += ax; y += ty >= sy ? 1 : -1; end
         first = 0;
      end
   endtask
   task automatic plan(input logic [7:0] x8, input logic [7:0] y8, input logic pen, input logic er);
      int d, tx, ty;
      logic wx, wy;
      d = $signed(x8);
      axis(mxa, d, 0, tx, wx);
      d = $signed(y8);
      axis(mya, d, 0, ty, wy);
      na = 0;
      if (pen) begin
         line(mxa, mya, tx, ty, mpp, er);
         na = tmp.size();
         foreach (tmp[k]) q[0].push_back(tmp[k]);
      end
      mxa = tx;
      mya = ty;
      d = $signed(x8) >>> 2;
      axis(mxb, d, 1, tx, wx);
      d = -($signed(y8) >>> 2);
      axis(myb, d, 1, ty, wy);
      nb = 0;
      if (pen) begin
         if (wx || wy) begin
            tmp.delete();
            tmp.push_back({er, PW'(tx), PW'(ty)});
         end else line(mxb, myb, tx, ty, mpp, er);
         nb = tmp.size();
         foreach (tmp[k]) q[1].push_back(tmp[k]);
      end
      mxb = tx;
      myb = ty;
      mpp = pen;
   endtask
   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while (!(ia.in_ready && ib.in_ready) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) begin
         cmp++;
         bad++;
         $display("FAIL idle_timeout: in_ready %b/%b after %0d cycles, required 1/1", ia.in_ready, ib.in_ready, k);
      end
   endtask
   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic l, input logic r);
      wait_idle();
      @(posedge clk);
      #1;
      ddx = x;
      ddy = y;
      bl = l;
      br = r;
      iv = 1;
      plan(x, y, l | r, r);
      @(posedge clk);
      #1 iv = 0;
      @(negedge clk);
      chk("busy_setup", ia.busy, 1);
      chk("setup_no_pix", ia.pix_valid, 0);
      @(negedge clk);
      chk("pos_a_x", ia.pos_x, mxa);
      chk("pos_a_y", ia.pos_y, mya);
      chk("pos_b_x", ib.pos_x, mxb);
      chk("pos_b_y", ib.pos_y, myb);
      if (na == 0) chk("empty_ret_a", ia.in_ready, 1);
      else chk("pix_rise_a", ia.pix_valid, 1);
      if (nb == 0) chk("empty_ret_b", ib.in_ready, 1);
      else chk("pix_rise_b", ib.pix_valid, 1);
   endtask
   task automatic mon(input int i, input logic v, input logic rdy, input logic [2*PW:0] cur);
      logic [2*PW:0] e;
      if (rst || !v) begin
         s[i] = 0;
         return;
      end
      if (s[i]) chk(i != 0 ? "stall_hold_b" : "stall_hold_a", cur, h[i]);
      if (rdy) begin
         hs[i]++;
         s[i] = 0;
         if (q[i].size() == 0) begin
            cmp++;
            bad++;
            $display("FAIL pix%0d: got unexpected pixel %h, required none", i, cur);
         end else begin
            e = q[i].pop_front();
            chk(i != 0 ? "pix_b" : "pix_a", cur, e);
         end
      end else begin
         s[i] = 1;
         h[i] = cur;
      end
   endtask
   initial forever begin
      @(negedge clk);
      mon(0, ia.pix_valid, ia.pix_ready, {ia.pix_erase, ia.pix_x, ia.pix_y});
      mon(1, ib.pix_valid, ib.pix_ready, {ib.pix_erase, ib.pix_x, ib.pix_y});
   end
   initial begin
      int k = 0;
      forever begin
         @(posedge clk);
         #1;
         k++;
         pr[0] = rmode == 0 ? 1'b1 : rmode == 1 ? k % 4 == 0 : 1'($urandom);
         pr[1] = rmode == 0 ? 1'b1 : 1'($urandom);
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      mxa = 32; mya = 32; mxb = 32; myb = 32; mpp = 0;
      @(negedge clk);
      chk("rst_pos_x", ia.pos_x, 32);
      chk("rst_pos_y", ia.pos_y, 32);
      chk("rst_in_ready", ia.in_ready, 1);
      chk("rst_busy", ia.busy, 0);
      chk("rst_pix_valid", ia.pix_valid, 0);
      chk("rst_pix", {ia.pix_erase, ia.pix_x, ia.pix_y}, 0);
      chk("rst_pos_b", {ib.pos_x, ib.pos_y}, {7'd32, 7'd32});
      send(8'd100, 8'd0, 0, 0);
      chk("clamp_hi", {ia.pos_x, ia.pos_y}, {7'd63, 7'd32});
      send(8'h80, 8'h80, 0, 0);
      chk("clamp_lo", {ia.pos_x, ia.pos_y}, {7'd0, 7'd0});
      send(8'd10, 8'd10, 0, 0);
      send(8'd4, 8'd2, 1, 0);
      repeat (4) @(negedge clk);
      chk("last_hs_busy", ia.in_ready, 0);
      @(negedge clk);
      chk("ready_after_last", ia.in_ready, 1);
      send(8'd2, 8'd0, 1, 0);
      send(8'd0, 8'd0, 1, 0);
      send(8'd0, 8'd0, 0, 0);
      rmode = 1;
      h0 = hs[0];
      send(8'd0, 8'd3, 0, 1);
      wait_idle();
      chk("bp_count", hs[0] - h0, 4);
      send(8'h80, 8'h80, 0, 0);
      send(8'd19, 8'd0, 1, 0);
      repeat (5) @(negedge clk);
      chk("mid_emit", ia.pix_valid, 1);
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("abort_pix_valid", ia.pix_valid, 0);
      chk("abort_pos", {ia.pos_x, ia.pos_y}, {7'd32, 7'd32});
      chk("abort_in_ready", ia.in_ready, 1);
      q[0].delete();
      q[1].delete();
      mxa = 32; mya = 32; mxb = 32; myb = 32; mpp = 0;
      rmode = 2;
      send(8'd120, 8'd108, 0, 0);
      chk("wrap_setup", {ib.pos_x, ib.pos_y}, {7'd62, 7'd5});
      h0 = hs[0];
      h1 = hs[1];
      send(8'd8, 8'hFF, 1, 0);
      chk("wrap_target", {ib.pos_x, ib.pos_y}, {7'd0, 7'd6});
      wait_idle();
      chk("pendown_after_rst", hs[0] - h0, 2);
      chk("wrap_single", hs[1] - h1, 1);
      repeat (150) begin
         logic [7:0] x, y;
         x = $urandom_range(0, 1) != 0 ? 8'($urandom) : 8'($urandom_range(0, 12)) - 8'd6;
         y = $urandom_range(0, 1) != 0 ? 8'($urandom) : 8'($urandom_range(0, 12)) - 8'd6;
         send(x, y, 1'($urandom), $urandom_range(0, 3) == 0);
      end
      wait_idle();
      repeat (2) @(negedge clk);
      chk("q_a_empty", q[0].size(), 0);
      chk("q_b_empty", q[1].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
